// File: rtl/piso_bitstream_gen.sv
// Parallel-in serial-out bit stream generator: WIDTH-bit words leave MSB first on x.
// Latency: first bit is on x in the cycle after the accepting edge; one bit per cycle after that.
// Backpressure: din_ready is low while a word is shifting (except the LSB cycle when GAP=0) and during idle gap cycles.
module piso_bitstream_gen #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int         CW       = $clog2(WIDTH);
    localparam logic [3:0] GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       gcnt_q, gcnt_d;
    logic             x_d, x_valid_d, done_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            x       <= x_d;
            x_valid <= x_valid_d;
            done    <= done_d;
        end
    end

    // sreg_q[WIDTH-1] always mirrors the bit currently on x; cnt_q is that bit's index.
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        gcnt_d    = gcnt_q;
        x_d       = 1'b0;
        x_valid_d = 1'b0;
        done_d    = 1'b0;
        din_ready = 1'b0;

        case (state_q)
            S_IDLE: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    state_d   = S_SHIFT;
                    sreg_d    = din;
                    cnt_d     = CW'(WIDTH - 1);
                    x_d       = din[WIDTH-1];
                    x_valid_d = 1'b1;
                end
            end
            S_SHIFT: begin
                if (cnt_q != '0) begin
                    sreg_d    = sreg_q << 1;
                    cnt_d     = cnt_q - 1'b1;
                    x_d       = sreg_q[WIDTH-2];
                    x_valid_d = 1'b1;
                    done_d    = (cnt_q == CW'(1));
                end else if (GAP == 0) begin
                    // LSB cycle with no gap: a waiting word streams on without a bubble.
                    din_ready = 1'b1;
                    if (din_valid) begin
                        sreg_d    = din;
                        cnt_d     = CW'(WIDTH - 1);
                        x_d       = din[WIDTH-1];
                        x_valid_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_GAP;
                    gcnt_d  = GAP_LAST;
                end
            end
            S_GAP: begin
                if (gcnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_piso_bitstream_gen.sv
// Directed bench for piso_bitstream_gen: three instances (8/0, 4/0, 4/2 width/gap) on a shared reset.
module tb_piso_bitstream_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [7:0] din8;
    logic       v8, r8, x8, xv8, b8, d8;
    logic [3:0] din4;
    logic       v4, r4, x4, xv4, b4, d4;
    logic [3:0] ding;
    logic       vg, rg, xg, xvg, bg, dg;

    int errs   = 0;
    int checks = 0;

    logic [2:0] hist = 3'b000;
    int         det  = 0;

    always #5 clk = ~clk;

    piso_bitstream_gen #(.WIDTH(8), .GAP(0)) u8 (
        .clk(clk), .rst(rst), .din(din8), .din_valid(v8), .din_ready(r8),
        .x(x8), .x_valid(xv8), .busy(b8), .done(d8)
    );

    piso_bitstream_gen #(.WIDTH(4), .GAP(0)) u4 (
        .clk(clk), .rst(rst), .din(din4), .din_valid(v4), .din_ready(r4),
        .x(x4), .x_valid(xv4), .busy(b4), .done(d4)
    );

    piso_bitstream_gen #(.WIDTH(4), .GAP(2)) u4g (
        .clk(clk), .rst(rst), .din(ding), .din_valid(vg), .din_ready(rg),
        .x(xg), .x_valid(xvg), .busy(bg), .done(dg)
    );

    // Downstream non-overlapping 1010 detector watching the 4-bit, no-gap stream.
    always @(negedge clk) begin
        if (xv4) begin
            if ({hist, x4} == 4'b1010) begin
                det++;
                hist <= 3'b000;
            end else begin
                hist <= {hist[1:0], x4};
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks one 8-bit word leaving u8; entered at the negedge on which the accept was set up.
    // During the word din8 is scrambled then set to nxt_din, so the LSB-cycle accept picks up nxt_din.
    task automatic stream8(input string tag, input logic [7:0] w,
                           input logic nxt_vld, input logic [7:0] nxt_din);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            chk({tag, "_x"},    32'(x8),  32'(w[i]));
            chk({tag, "_xv"},   32'(xv8), 32'd1);
            chk({tag, "_done"}, 32'(d8),  32'(i == 0));
            chk({tag, "_rdy"},  32'(r8),  32'(i == 0));
            chk({tag, "_busy"}, 32'(b8),  32'd1);
            if (i == 7) begin
                v8   = nxt_vld;
                din8 = ~nxt_din;
            end
            if (i == 3) din8 = nxt_din;
        end
    endtask

    initial begin
        logic [7:0] c3;
        logic [3:0] pa, p9, p6;
        c3 = 8'hC3;
        pa = 4'hA;
        p9 = 4'h9;
        p6 = 4'h6;

        // Reset held for two edges with valid asserted everywhere.
        din8 = 8'hA5; v8 = 1'b1;
        din4 = 4'hA;  v4 = 1'b1;
        ding = 4'h9;  vg = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_x",    32'(x8),  32'd0);
            chk("rst_xv",   32'(xv8), 32'd0);
            chk("rst_busy", 32'(b8),  32'd0);
            chk("rst_done", 32'(d8),  32'd0);
            chk("rst_xv4",  32'(xv4), 32'd0);
            chk("rst_xvg",  32'(xvg), 32'd0);
        end
        rst = 1'b1; v8 = 1'b0; v4 = 1'b0; vg = 1'b0;
        chk("rel_rdy8", 32'(r8), 32'd1);
        chk("rel_rdyg", 32'(rg), 32'd1);
        @(negedge clk);
        chk("idle_xv",   32'(xv8), 32'd0);
        chk("idle_busy", 32'(b8),  32'd0);

        // Single 8'hA5 word, then back to idle.
        din8 = 8'hA5; v8 = 1'b1;
        stream8("a5", 8'hA5, 1'b0, 8'h00);
        @(negedge clk);
        chk("a5_end_xv",   32'(xv8), 32'd0);
        chk("a5_end_x",    32'(x8),  32'd0);
        chk("a5_end_busy", 32'(b8),  32'd0);
        chk("a5_end_rdy",  32'(r8),  32'd1);

        // Backpressure: 8'h0F waits behind 8'hF0, din wiggles while ignored.
        din8 = 8'hF0; v8 = 1'b1;
        stream8("f0", 8'hF0, 1'b1, 8'h0F);
        v8 = 1'b1;
        stream8("0f", 8'h0F, 1'b0, 8'h00);
        @(negedge clk);
        chk("0f_end_xv", 32'(xv8), 32'd0);

        // Back-to-back 4'hA words with no bubble.
        din4 = 4'hA; v4 = 1'b1;
        chk("b2b_rdy0", 32'(r4), 32'd1);
        for (int k = 0; k < 2; k++) begin
            for (int i = 3; i >= 0; i--) begin
                @(negedge clk);
                chk("b2b_x",    32'(x4),  32'(pa[i]));
                chk("b2b_xv",   32'(xv4), 32'd1);
                chk("b2b_done", 32'(d4),  32'(i == 0));
                if (k == 1 && i == 3) v4 = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b_end_xv",   32'(xv4), 32'd0);
        chk("b2b_end_busy", 32'(b4),  32'd0);
        chk("b2b_det",      32'(det), 32'd2);

        // GAP=2: 4'h9, two gap cycles, one idle accept cycle, then 4'h6.
        ding = 4'h9; vg = 1'b1;
        chk("gap_rdy0", 32'(rg), 32'd1);
        for (int i = 3; i >= 0; i--) begin
            @(negedge clk);
            chk("gap9_x",    32'(xg),  32'(p9[i]));
            chk("gap9_xv",   32'(xvg), 32'd1);
            chk("gap9_done", 32'(dg),  32'(i == 0));
            chk("gap9_rdy",  32'(rg),  32'd0);
            if (i == 3) ding = 4'h6;
        end
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            chk("gap_idle_xv",   32'(xvg), 32'd0);
            chk("gap_idle_x",    32'(xg),  32'd0);
            chk("gap_idle_rdy",  32'(rg),  32'd0);
            chk("gap_idle_busy", 32'(bg),  32'd1);
        end
        @(negedge clk);
        chk("gap_acc_xv",   32'(xvg), 32'd0);
        chk("gap_acc_rdy",  32'(rg),  32'd1);
        chk("gap_acc_busy", 32'(bg),  32'd0);
        for (int i = 3; i >= 0; i--) begin
            @(negedge clk);
            chk("gap6_x",    32'(xg),  32'(p6[i]));
            chk("gap6_xv",   32'(xvg), 32'd1);
            chk("gap6_done", 32'(dg),  32'(i == 0));
            if (i == 3) vg = 1'b0;
        end
        @(negedge clk);
        chk("gap6_end_xv", 32'(xvg), 32'd0);

        // Reset after three bits of 8'hC3; the next word restarts from its MSB.
        din8 = 8'hC3; v8 = 1'b1;
        for (int i = 7; i >= 5; i--) begin
            @(negedge clk);
            chk("mid_x", 32'(x8), 32'(c3[i]));
            if (i == 7) v8 = 1'b0;
            if (i == 5) rst = 1'b0;
        end
        @(negedge clk);
        chk("mid_rst_x",    32'(x8),  32'd0);
        chk("mid_rst_xv",   32'(xv8), 32'd0);
        chk("mid_rst_busy", 32'(b8),  32'd0);
        chk("mid_rst_done", 32'(d8),  32'd0);
        rst = 1'b1; din8 = 8'h81; v8 = 1'b1;
        chk("mid_rel_rdy", 32'(r8), 32'd1);
        stream8("post", 8'h81, 1'b0, 8'h00);
        @(negedge clk);
        chk("post_end_xv", 32'(xv8), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
